// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter:
// FSM states, requester identities and default wait count.
package mypack;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    typedef enum logic {
        IF,
        LS
    } requester_t;

    localparam int MEM_WAIT_DEFAULT = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Two-way round-robin selector: a lone requester wins,
// on contention the one not granted last time wins.
module rr_pick
    import mypack::*;
(
    input  logic [1:0] req,
    input  requester_t last,
    output logic [1:0] grant,
    output requester_t winner
);

    always_comb begin
        winner = IF;
        grant  = 2'b00;
        if (req[0] && req[1]) begin
            winner = (last == LS) ? IF : LS;
        end else if (req[1]) begin
            winner = LS;
        end
        if (req != 2'b00) begin
            grant = (winner == LS) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between fetch and load/store,
// one transaction at a time with a fixed wait count and a one-cycle ack.
module mem_port_arbiter
    import mypack::*;
#(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = MEM_WAIT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ack,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [DW/8-1:0] ls_be,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    output logic [DW-1:0]   ls_rdata,
    output logic            ls_ack,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);

    localparam int BW = DW / 8;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    arb_state_t state;
    arb_state_t next;
    requester_t owner;
    requester_t last_grant;
    requester_t winner;
    logic [1:0] grant;
    logic [3:0] cnt;
    logic          we_q;
    logic [BW-1:0] be_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] ls_rdata_q;

    rr_pick u_pick (
        .req    ({ls_req, if_req}),
        .last   (last_grant),
        .grant  (grant),
        .winner (winner)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (grant != 2'b00) next = ACCESS;
            ACCESS:  if (cnt == 4'd0) next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= IF;
            last_grant <= LS;
            cnt        <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state <= next;
            if (state == IDLE && grant != 2'b00) begin
                owner      <= winner;
                last_grant <= winner;
                cnt        <= WAIT_CNT;
                // Fetch is always a full-word read.
                if (winner == LS) begin
                    we_q    <= ls_we;
                    be_q    <= ls_be;
                    addr_q  <= ls_addr;
                    wdata_q <= ls_wdata;
                end else begin
                    we_q    <= 1'b0;
                    be_q    <= '1;
                    addr_q  <= if_addr;
                    wdata_q <= '0;
                end
            end
            if (state == ACCESS) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else if (!we_q) begin
                    if (owner == IF) if_rdata_q <= mem_rdata;
                    else             ls_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en && we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ack    = (state == DONE) && (owner == IF);
    assign ls_ack    = (state == DONE) && (owner == LS);
    assign busy      = (state != IDLE);
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single synchronous memory port between the instruction-fetch requester and the load/store requester, both driven by the microcoded control unit. It grants one transaction at a time, holds the memory signals stable for a parameterised number of wait cycles, captures read data and returns a one-cycle acknowledge to the granted requester. When both requesters contend, they alternate round-robin so neither starves.

## Interface
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- WAIT, 2, extra memory cycles per access (0..15); an access holds the port for WAIT+1 cycles
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched word; valid in the if_ack cycle, held until the next fetch completes
- if_ack  out  1  one-cycle completion pulse
- ls_req  in  1  load/store request, level, held until ls_ack
- ls_we  in  1  1 = store
- ls_be  in  DW/8  store byte enables
- ls_addr  in  AW  data address
- ls_wdata  in  DW  store data
- ls_rdata  out  DW  load data; valid in the ls_ack cycle; stores do not update it
- ls_ack  out  1  one-cycle completion pulse
- mem_en  out  1  memory access active
- mem_we  out  1  memory write
- mem_be  out  DW/8  byte enables (all ones for reads)
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  memory read data, valid from the last ACCESS cycle
- busy  out  1  high in ACCESS and DONE

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any req is high at an edge, grant and go to ACCESS. Latch owner, we, be, addr and wdata into registers. Wait counter loads WAIT.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the requester not granted last time wins.
  - last_grant resets to LS, so the first contention goes to IF.
- ACCESS:
  - mem_en=1. mem_we, mem_be, mem_addr and mem_wdata are driven from the latched registers, so they are stable even if inputs change.
  - Counter decrements each cycle. At count 0, go to DONE; on a read, capture mem_rdata into the owner's rdata register on that edge.
- DONE:
  - Owner's ack=1 for exactly one cycle. mem_en=0.
  - Always return to IDLE. Arbitration happens only in IDLE, so there are no back-to-back grants.
- Requester drops req mid-transaction: the access still completes and ack is still pulsed. There is no abort.
- ls_we is ignored for fetch. Fetch is always a read with mem_be all ones.
- Reset values:
  - State IDLE, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - if_ack=0, ls_ack=0, busy=0, if_rdata=0, ls_rdata=0, last_grant=LS.
- Reset mid-access: next cycle is IDLE with all outputs at reset values. No ack is issued and the pending request is simply re-arbitrated after reset.

## Timing
- Request seen high at edge k (IDLE): ACCESS for cycles k..k+WAIT, with mem_en high for WAIT+1 cycles.
- Read data sampled at edge k+WAIT+1. Ack high during cycle k+WAIT+1. IDLE again from edge k+WAIT+2.
- Occupancy is WAIT+2 cycles per transaction. Peak throughput is one access per WAIT+3 cycles, because IDLE takes one cycle.
- All outputs are registered or decoded from state/registers only. There is no combinational path from req or addr to mem_* or ack.

## Structure
- Shared package (mypack) gets:
  - `arb_state_t` enum {IDLE, ACCESS, DONE}
  - `requester_t` enum {IF, LS}
  - constant `MEM_WAIT_DEFAULT` = 2
- One sub-module, `rr_pick`: combinational two-way round-robin selector.
  - Inputs: req[1:0], last.
  - Outputs: grant one-hot, winner.
  - Used only in IDLE.
- Top holds the FSM, counter, latches and rdata registers (about 180 lines).

## Test plan
- Reset, then a single fetch if_addr=0x40 with mem returning 0x00500093, WAIT=2: mem_en high for 3 cycles with mem_addr=0x40 and mem_be=0xF; if_ack pulses in cycle 4; if_rdata=0x00500093.
- Store ls_addr=0x100, ls_wdata=0xDEADBEEF, ls_be=0x3: mem_we=1 and mem_be=0x3 throughout ACCESS; ls_ack pulses once; ls_rdata unchanged.
- if_req and ls_req both held high over 4 grants: grant order IF, LS, IF, LS; each ack is exactly one cycle; mem_en is never high in DONE or IDLE.
- ls_req dropped and ls_addr changed to 0x0 in the second ACCESS cycle: mem_addr stays 0x100 and ls_ack still pulses.
- rst asserted in the middle ACCESS cycle: next cycle mem_en=0, busy=0, no ack. With the request still high after reset, it restarts and completes normally.
- WAIT=0 build: mem_en is high for exactly 1 cycle and ack follows on the next cycle.
